muldiv_seq: RTL



---
 rtl/muldiv_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq -- multi-cycle RV32M multiply/divide sequencer.
//
// Works on operand magnitudes. A shift-add multiplier or a restoring divider
// runs for XLEN iterations. A single FIXUP cycle then restores signs and
// selects the result half.
//
// Divide-by-zero and signed overflow are resolved at acceptance. They go
// straight to DONE.
//
// resp_valid is registered one edge after DONE is entered. This gives:
//   - XLEN+2 edges for iterative ops,
//   - 2 edges for fast multiply,
//   - 1 edge for special cases.
//
// Optional: `define MULDIV_FAST_MUL_EN replaces the iterative MUL state with a
// combinational product evaluated in FIXUP. Divide is unaffected.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_funct3, req_rs1/rs2    RV32M op select and operands
//   resp_valid/resp_ready      response handshake
//   resp_result                result, stable while resp_valid
//   busy                       high in any non-IDLE state (core stall)
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state;
  logic [2:0]          f3;
  logic                sa, sb;        // operand signs (0 for unsigned positions)
  logic [XLEN-1:0]     a_abs, b_abs;
  logic [CNT_W-1:0]    cnt;
  logic [2*XLEN-1:0]   acc;           // hi: partial sum, lo: remaining multiplier bits
  logic [XLEN-1:0]     quo;           // dividend shifts out MSB-first, quotient shifts in
  logic [XLEN:0]       rem;

  // ---------------- acceptance-side decode ----------------
  logic            sgn_a_op, sgn_b_op;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a_in, abs_b_in;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    sgn_a_op = 1'b0;
    sgn_b_op = 1'b0;
    unique case (req_funct3)
      3'b001, 3'b100, 3'b110: begin sgn_a_op = 1'b1; sgn_b_op = 1'b1; end
      3'b010:                 sgn_a_op = 1'b1;
      default: ;
    endcase
    a_neg    = sgn_a_op & req_rs1[XLEN-1];
    b_neg    = sgn_b_op & req_rs2[XLEN-1];
    abs_a_in = a_neg ? -req_rs1 : req_rs1;
    abs_b_in = b_neg ? -req_rs2 : req_rs2;
    div_zero = req_funct3[2] && (req_rs2 == '0);
    // Overflow only exists for the signed forms (DIV/REM: funct3[0]=0).
    div_ovf  = req_funct3[2] && !req_funct3[0] &&
               (req_rs1 == MIN_NEG) && (&req_rs2);
    special_res = '0;
    if (div_zero)     special_res = req_funct3[1] ? req_rs1 : '1;
    else if (div_ovf) special_res = req_funct3[1] ? '0      : req_rs1;
  end

  // ---------------- datapath steps ----------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN+1:0] div_trial;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_abs} : '0);
    // Shift in the next dividend bit, then subtract the divisor.
    // The extra top bit is the borrow.
    div_trial = {rem, quo[XLEN-1]} - {2'b00, b_abs};
  end

  // ---------------- fixup ----------------
  logic [2*XLEN-1:0] prod_raw, prod;
  logic [XLEN-1:0]   q_out, r_out, fix_result;

  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_raw = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
`else
    prod_raw = acc;
`endif
    prod  = (sa ^ sb) ? -prod_raw : prod_raw;
    q_out = (sa ^ sb) ? -quo : quo;
    r_out = sa ? -rem[XLEN-1:0] : rem[XLEN-1:0];   // remainder follows dividend
    if (f3[2])           fix_result = f3[1] ? r_out : q_out;
    else if (f3 == 3'b0) fix_result = prod[XLEN-1:0];
    else                 fix_result = prod[2*XLEN-1:XLEN];
  end

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      f3          <= '0;
      sa          <= 1'b0;
      sb          <= 1'b0;
      a_abs       <= '0;
      b_abs       <= '0;
      cnt         <= '0;
      acc         <= '0;
      quo         <= '0;
      rem         <= '0;
      resp_result <= '0;
      resp_valid  <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid && req_ready) begin
          f3        <= req_funct3;
          sa        <= a_neg;
          sb        <= b_neg;
          a_abs     <= abs_a_in;
          b_abs     <= abs_b_in;
          cnt       <= CNT_W'(XLEN);
          req_ready <= 1'b0;
          busy      <= 1'b1;
          if (div_zero || div_ovf) begin
            resp_result <= special_res;
            state       <= S_DONE;
          end else if (req_funct3[2]) begin
            quo   <= abs_a_in;
            rem   <= '0;
            state <= S_DIV;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            state <= S_FIXUP;
`else
            acc   <= {{XLEN{1'b0}}, abs_b_in};
            state <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[XLEN-1:1]};
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_FIXUP;
        end
        S_DIV: begin
          if (div_trial[XLEN+1]) begin
            rem <= {rem[XLEN-1:0], quo[XLEN-1]};      // restore
            quo <= {quo[XLEN-2:0], 1'b0};
          end else begin
            rem <= div_trial[XLEN:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= S_FIXUP;
        end
        S_FIXUP: begin
          resp_result <= fix_result;
          state       <= S_DONE;
        end
        S_DONE: begin
          // resp_valid lags DONE entry by one edge.
          // Only a presented response can be consumed.
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end else begin
            resp_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
